// File: rtl/sik_mem_arbiter.sv
// Round-robin sharing of the SIK data-memory port between two threads, with a
// read-tag pipeline that steers returning read data back to the issuing thread.
`timescale 1ns/1ps
module sik_mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          halt0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          halt1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          all_halted
);

  logic               w_ereq0;
  logic               w_ereq1;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_anyGnt;
  logic               w_rdIssue;
  logic               w_exitValid;
  logic               w_exitId;
  logic               w_inflight;
  logic               r_prio;
  logic [MEM_LAT-1:0] r_tagValid;
  logic [MEM_LAT-1:0] r_tagId;

  assign w_ereq0  = req0 & ~halt0;
  assign w_ereq1  = req1 & ~halt1;
  // r_prio names the thread that wins when both threads contend.
  assign w_gnt0   = w_ereq0 & (~w_ereq1 | ~r_prio);
  assign w_gnt1   = w_ereq1 & (~w_ereq0 | r_prio);
  assign w_anyGnt = w_gnt0 | w_gnt1;

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign mem_en    = w_anyGnt;
  assign mem_we    = w_gnt0 ? we0    : (w_gnt1 ? we1    : 1'b0);
  assign mem_addr  = w_gnt0 ? addr0  : (w_gnt1 ? addr1  : '0);
  assign mem_wdata = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);
  assign w_rdIssue = w_anyGnt & ~mem_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio <= 1'b0;
    end else if (w_anyGnt) begin
      r_prio <= w_gnt0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tagValid <= '0;
      r_tagId    <= '0;
    end else begin
      r_tagValid[0] <= w_rdIssue;
      r_tagId[0]    <= w_gnt1;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagId[i]    <= r_tagId[i-1];
      end
    end
  end

  assign w_exitValid = r_tagValid[MEM_LAT-1];
  assign w_exitId    = r_tagId[MEM_LAT-1];
  assign rvalid0     = w_exitValid & ~w_exitId;
  assign rvalid1     = w_exitValid & w_exitId;
  assign rdata0      = rvalid0 ? mem_rdata : '0;
  assign rdata1      = rvalid1 ? mem_rdata : '0;

  // The tag in the exit stage is being returned this cycle, so it no longer counts as outstanding.
  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i < MEM_LAT - 1; i++) begin
      w_inflight = w_inflight | r_tagValid[i];
    end
  end

  assign all_halted = halt0 & halt1 & ~w_inflight;

endmodule

// File: tb/tb_sik_mem_arbiter.sv
// Bench for sik_mem_arbiter: three instances (MEM_LAT 1, 2, 3) share stimulus; directed
// scenarios plus a randomized run checked against a cycle-indexed log of issued reads.
`timescale 1ns/1ps
module tb_sik_mem_arbiter;
  localparam int NI = 3;
  localparam int NR = 400;

  logic clk = 1'b0;
  logic reset;
  logic req0, we0, halt0, req1, we1, halt1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic [NI-1:0] gnt0V, gnt1V, rvalid0V, rvalid1V, memEnV, memWeV, allHaltedV;
  logic [NI-1:0][15:0] rdata0V, rdata1V, memAddrV, memWdataV, memRdataV;

  int nChecks = 0;
  int nPass   = 0;
  logic [15:0] modelMem [256];
  logic        issuedValid [NR];
  logic        issuedTid [NR];
  logic [15:0] issuedData [NR];

  always #5 clk = ~clk;

  function automatic logic [15:0] memInit(int i);
    if (i == 'h10) return 16'hBEEF;
    return 16'(i * 257) ^ 16'h5A00;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gInst
    localparam int LAT = g + 1;
    logic [15:0] memArr [256];
    logic [15:0] rdPipe [LAT];

    initial begin
      for (int i = 0; i < 256; i++) memArr[i] <= memInit(i);
      for (int i = 0; i < LAT; i++) rdPipe[i] <= 16'h0;
    end

    // Synchronous memory model whose read data appears LAT cycles after the command.
    always @(posedge clk) begin
      if (memEnV[g] && memWeV[g]) memArr[memAddrV[g][7:0]] <= memWdataV[g];
      rdPipe[0] <= (memEnV[g] && !memWeV[g]) ? memArr[memAddrV[g][7:0]] : 16'h0;
      for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign memRdataV[g] = rdPipe[LAT-1];

    sik_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .halt0(halt0),
      .gnt0(gnt0V[g]), .rvalid0(rvalid0V[g]), .rdata0(rdata0V[g]),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .halt1(halt1),
      .gnt1(gnt1V[g]), .rvalid1(rvalid1V[g]), .rdata1(rdata1V[g]),
      .mem_en(memEnV[g]), .mem_we(memWeV[g]), .mem_addr(memAddrV[g]),
      .mem_wdata(memWdataV[g]), .mem_rdata(memRdataV[g]), .all_halted(allHaltedV[g])
    );
  end

  task automatic applyStimulus(input logic r0, input logic w0, input logic [15:0] a0,
                               input logic [15:0] d0, input logic h0,
                               input logic r1, input logic w1, input logic [15:0] a1,
                               input logic [15:0] d1, input logic h1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; halt0 = h0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; halt1 = h1;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idleInputs();
    @(negedge clk);
    nChecks++; if ({rvalid0V, rvalid1V} !== '0) $display("[TB] FAIL reset_rvalid: got %b expected 0", {rvalid0V, rvalid1V}); else nPass++;
    nChecks++; if ({rdata0V, rdata1V} !== '0) $display("[TB] FAIL reset_rdata: got %h expected 0", {rdata0V, rdata1V}); else nPass++;
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    nChecks++; if ({gnt0V, gnt1V, memEnV} !== '0) $display("[TB] FAIL idle_gnt_en: got %b expected 0", {gnt0V, gnt1V, memEnV}); else nPass++;
    nChecks++; if ({memAddrV, memWdataV, memWeV} !== '0) $display("[TB] FAIL idle_mem: got %h expected 0", {memAddrV, memWdataV, memWeV}); else nPass++;
    nChecks++; if (allHaltedV !== '0) $display("[TB] FAIL idle_all_halted: got %b expected 000", allHaltedV); else nPass++;
    nextCycle();
    halt0 = 1'b1; halt1 = 1'b1;
    @(negedge clk);
    nChecks++; if (allHaltedV !== '1) $display("[TB] FAIL halted_all_halted: got %b expected 111", allHaltedV); else nPass++;
    nextCycle();
    idleInputs();
  endtask

  task automatic test_single_read();
    logic expV;
    logic [15:0] expD;
    doReset();
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    nChecks++; if (gnt0V !== '1 || gnt1V !== '0) $display("[TB] FAIL single_gnt: got %b/%b expected 111/000", gnt0V, gnt1V); else nPass++;
    nChecks++; if (memEnV !== '1 || memWeV !== '0) $display("[TB] FAIL single_en_we: got %b/%b expected 111/000", memEnV, memWeV); else nPass++;
    nChecks++; if (memAddrV !== {NI{16'h0010}}) $display("[TB] FAIL single_addr: got %h expected %h", memAddrV, {NI{16'h0010}}); else nPass++;
    nextCycle();
    idleInputs();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        expV = (k == g + 1);
        expD = expV ? 16'hBEEF : 16'h0;
        nChecks++; if (rvalid0V[g] !== expV) $display("[TB] FAIL single_rvalid0 lat%0d cyc%0d: got %b expected %b", g + 1, k, rvalid0V[g], expV); else nPass++;
        nChecks++; if (rdata0V[g] !== expD) $display("[TB] FAIL single_rdata0 lat%0d cyc%0d: got %h expected %h", g + 1, k, rdata0V[g], expD); else nPass++;
        nChecks++; if (rvalid1V[g] !== 1'b0) $display("[TB] FAIL single_rvalid1 lat%0d cyc%0d: got %b expected 0", g + 1, k, rvalid1V[g]); else nPass++;
      end
      nextCycle();
    end
  endtask

  task automatic test_alternating();
    int src;
    logic expV0, expV1;
    logic [15:0] expD0, expD1;
    doReset();
    applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 6) idleInputs();
      @(negedge clk);
      if (k < 6) begin
        nChecks++; if (gnt0V !== {NI{k % 2 == 0}} || gnt1V !== {NI{k % 2 == 1}}) $display("[TB] FAIL alt_gnt cyc%0d: got %b/%b expected thread %0d", k, gnt0V, gnt1V, k % 2); else nPass++;
        nChecks++; if (memAddrV !== {NI{(k % 2 == 0) ? 16'd1 : 16'd2}}) $display("[TB] FAIL alt_addr cyc%0d: got %h expected thread %0d address", k, memAddrV, k % 2); else nPass++;
      end
      for (int g = 0; g < NI; g++) begin
        src   = k - (g + 1);
        expV0 = (src >= 0) && (src < 6) && (src % 2 == 0);
        expV1 = (src >= 0) && (src < 6) && (src % 2 == 1);
        expD0 = expV0 ? memInit(1) : 16'h0;
        expD1 = expV1 ? memInit(2) : 16'h0;
        nChecks++; if (rvalid0V[g] !== expV0 || rdata0V[g] !== expD0) $display("[TB] FAIL alt_t0 lat%0d cyc%0d: got %b/%h expected %b/%h", g + 1, k, rvalid0V[g], rdata0V[g], expV0, expD0); else nPass++;
        nChecks++; if (rvalid1V[g] !== expV1 || rdata1V[g] !== expD1) $display("[TB] FAIL alt_t1 lat%0d cyc%0d: got %b/%h expected %b/%h", g + 1, k, rvalid1V[g], rdata1V[g], expV1, expD1); else nPass++;
      end
      nextCycle();
    end
  endtask

  task automatic test_store_then_load();
    int lat;
    logic expV0, expV1;
    logic [15:0] expD0, expD1;
    doReset();
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        1: applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0);
        2: applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        3: applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
        default: idleInputs();
      endcase
      @(negedge clk);
      if (c == 1) begin
        nChecks++; if (gnt1V !== '1 || gnt0V !== '0) $display("[TB] FAIL store_gnt: got %b/%b expected 000/111", gnt0V, gnt1V); else nPass++;
        nChecks++; if (memWeV !== '1) $display("[TB] FAIL store_we: got %b expected 111", memWeV); else nPass++;
        nChecks++; if (memAddrV !== {NI{16'h0020}} || memWdataV !== {NI{16'h1234}}) $display("[TB] FAIL store_cmd: got %h/%h expected 0020/1234", memAddrV, memWdataV); else nPass++;
      end
      if (c == 2) begin
        nChecks++; if (gnt0V !== '1 || gnt1V !== '0 || memWeV !== '0) $display("[TB] FAIL load_after_store_gnt: got %b/%b we %b", gnt0V, gnt1V, memWeV); else nPass++;
        nChecks++; if (memAddrV !== {NI{16'h0003}}) $display("[TB] FAIL load_after_store_addr: got %h expected 0003", memAddrV); else nPass++;
      end
      for (int g = 0; g < NI; g++) begin
        lat   = g + 1;
        expV0 = (c == lat) || (c == lat + 2);
        expD0 = (c == lat) ? 16'hBEEF : ((c == lat + 2) ? memInit(3) : 16'h0);
        expV1 = (c == lat + 3);
        expD1 = expV1 ? 16'h1234 : 16'h0;
        nChecks++; if (rvalid0V[g] !== expV0 || rdata0V[g] !== expD0) $display("[TB] FAIL store_t0 lat%0d cyc%0d: got %b/%h expected %b/%h", lat, c, rvalid0V[g], rdata0V[g], expV0, expD0); else nPass++;
        nChecks++; if (rvalid1V[g] !== expV1 || rdata1V[g] !== expD1) $display("[TB] FAIL store_t1 lat%0d cyc%0d: got %b/%h expected %b/%h", lat, c, rvalid1V[g], rdata1V[g], expV1, expD1); else nPass++;
      end
      nextCycle();
    end
  endtask

  task automatic test_halt_drain();
    int lat;
    logic expV, expH;
    doReset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      else        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        lat  = g + 1;
        expV = (c == lat);
        nChecks++; if (rvalid0V[g] !== expV || rdata0V[g] !== (expV ? 16'hBEEF : 16'h0)) $display("[TB] FAIL drain_rvalid lat%0d cyc%0d: got %b/%h expected %b", lat, c, rvalid0V[g], rdata0V[g], expV); else nPass++;
        if (c != lat) begin
          expH = (c > lat);
          nChecks++; if (allHaltedV[g] !== expH) $display("[TB] FAIL drain_all_halted lat%0d cyc%0d: got %b expected %b", lat, c, allHaltedV[g], expH); else nPass++;
        end
      end
      nextCycle();
    end
    idleInputs();
  endtask

  task automatic test_reset_mid();
    doReset();
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    nChecks++; if (gnt0V !== '1) $display("[TB] FAIL midrst_first_gnt: got %b expected 111", gnt0V); else nPass++;
    nextCycle();
    idleInputs();
    reset = 1'b1;
    @(negedge clk);
    nChecks++; if ({rvalid0V, rvalid1V} !== '0 || {rdata0V, rdata1V} !== '0) $display("[TB] FAIL midrst_during: got %b/%h expected 0", {rvalid0V, rvalid1V}, {rdata0V, rdata1V}); else nPass++;
    nextCycle();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nChecks++; if ({rvalid0V, rvalid1V} !== '0) $display("[TB] FAIL midrst_stale cyc%0d: got %b expected 0", k, {rvalid0V, rvalid1V}); else nPass++;
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0, 1'b0);
    @(negedge clk);
    nChecks++; if (gnt0V !== '1 || gnt1V !== '0) $display("[TB] FAIL midrst_prio_first: got %b/%b expected 111/000", gnt0V, gnt1V); else nPass++;
    nextCycle();
    @(negedge clk);
    nChecks++; if (gnt1V !== '1 || gnt0V !== '0) $display("[TB] FAIL midrst_prio_second: got %b/%b expected 000/111", gnt0V, gnt1V); else nPass++;
    nextCycle();
    idleInputs();
  endtask

  task automatic test_random();
    logic act0, act1, rw0, rw1, h0, h1, favour;
    logic [15:0] ra0, ra1, rd0, rd1;
    logic e0, e1, g0, g1, expWe, expV0, expV1, inflight, expH;
    logic [15:0] expAddr, expWd, expD0, expD1;
    int s;
    for (int i = 0; i < 256; i++) modelMem[i] = memInit(i);
    modelMem[8'h20] = 16'h1234;
    for (int i = 0; i < NR; i++) issuedValid[i] = 1'b0;
    act0 = 1'b0; act1 = 1'b0; h0 = 1'b0; h1 = 1'b0; favour = 1'b0;
    rw0 = 1'b0; rw1 = 1'b0; ra0 = 16'h0; ra1 = 16'h0; rd0 = 16'h0; rd1 = 16'h0;
    doReset();
    for (int t = 0; t < NR; t++) begin
      if (!act0 && $urandom_range(0, 1) == 1) begin
        act0 = 1'b1; rw0 = 1'($urandom_range(0, 1)); ra0 = 16'($urandom_range(0, 255)); rd0 = 16'($urandom);
      end
      if (!act1 && $urandom_range(0, 1) == 1) begin
        act1 = 1'b1; rw1 = 1'($urandom_range(0, 1)); ra1 = 16'($urandom_range(0, 255)); rd1 = 16'($urandom);
      end
      if ($urandom_range(0, 9) == 0) h0 = ~h0;
      if ($urandom_range(0, 9) == 0) h1 = ~h1;
      applyStimulus(act0, rw0, ra0, rd0, h0, act1, rw1, ra1, rd1, h1);
      @(negedge clk);
      e0 = act0 && !h0;
      e1 = act1 && !h1;
      g0 = e0 && (!e1 || favour == 1'b0);
      g1 = e1 && !g0;
      expWe   = g0 ? rw0 : (g1 ? rw1 : 1'b0);
      expAddr = g0 ? ra0 : (g1 ? ra1 : 16'h0);
      expWd   = g0 ? rd0 : (g1 ? rd1 : 16'h0);
      nChecks++; if (gnt0V !== {NI{g0}} || gnt1V !== {NI{g1}}) $display("[TB] FAIL rnd_gnt t%0d: got %b/%b expected %b/%b", t, gnt0V, gnt1V, g0, g1); else nPass++;
      nChecks++; if (memEnV !== {NI{g0 | g1}} || memWeV !== {NI{expWe}}) $display("[TB] FAIL rnd_en_we t%0d: got %b/%b expected %b/%b", t, memEnV, memWeV, g0 | g1, expWe); else nPass++;
      nChecks++; if (memAddrV !== {NI{expAddr}} || memWdataV !== {NI{expWd}}) $display("[TB] FAIL rnd_cmd t%0d: got %h/%h expected %h/%h", t, memAddrV, memWdataV, expAddr, expWd); else nPass++;
      for (int g = 0; g < NI; g++) begin
        s = t - (g + 1);
        expV0 = (s >= 0) && issuedValid[s] && (issuedTid[s] == 1'b0);
        expV1 = (s >= 0) && issuedValid[s] && (issuedTid[s] == 1'b1);
        expD0 = expV0 ? issuedData[s] : 16'h0;
        expD1 = expV1 ? issuedData[s] : 16'h0;
        nChecks++; if (rvalid0V[g] !== expV0 || rdata0V[g] !== expD0) $display("[TB] FAIL rnd_t0 lat%0d t%0d: got %b/%h expected %b/%h", g + 1, t, rvalid0V[g], rdata0V[g], expV0, expD0); else nPass++;
        nChecks++; if (rvalid1V[g] !== expV1 || rdata1V[g] !== expD1) $display("[TB] FAIL rnd_t1 lat%0d t%0d: got %b/%h expected %b/%h", g + 1, t, rvalid1V[g], rdata1V[g], expV1, expD1); else nPass++;
        inflight = 1'b0;
        for (int s2 = s + 1; s2 < t; s2++) if (s2 >= 0 && issuedValid[s2]) inflight = 1'b1;
        if (!expV0 && !expV1) begin
          expH = h0 && h1 && !inflight;
          nChecks++; if (allHaltedV[g] !== expH) $display("[TB] FAIL rnd_all_halted lat%0d t%0d: got %b expected %b", g + 1, t, allHaltedV[g], expH); else nPass++;
        end
      end
      issuedValid[t] = (g0 && !rw0) || (g1 && !rw1);
      issuedTid[t]   = g1;
      issuedData[t]  = modelMem[expAddr[7:0]];
      if ((g0 || g1) && expWe) modelMem[expAddr[7:0]] = expWd;
      if (g0) begin act0 = 1'b0; favour = 1'b1; end
      if (g1) begin act1 = 1'b0; favour = 1'b0; end
      nextCycle();
    end
    idleInputs();
  endtask

  initial begin
    reset = 1'b1;
    idleInputs();
    test_reset();
    test_single_read();
    test_alternating();
    test_store_then_load();
    test_halt_drain();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sik_mem_arbiter.md
Name: sik_mem_arbiter

Overview:
- Shares the single data-memory port of the two-thread SIK pipelined processor between thread 0 and thread 1 load/store stages.
- Grants one access per cycle using round-robin priority, drives the memory command, and returns read data to the issuing thread after a fixed memory latency.
- Tracks outstanding reads so the top level can tell when both threads are halted and the memory is quiescent.

Parameters:
- AW, 16, memory address width.
- DW, 16, memory data width; matches the processor WORD.
- MEM_LAT, 1, cycles from a read command to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  thread 0 access request.
- we0  in  1  thread 0 write enable: 1=store, 0=load.
- addr0  in  AW  thread 0 address.
- wdata0  in  DW  thread 0 store data.
- halt0  in  1  thread 0 halted; masks req0.
- gnt0  out  1  thread 0 request accepted this cycle.
- rvalid0  out  1  thread 0 read data valid.
- rdata0  out  DW  thread 0 read data.
- req1/we1/addr1/wdata1/halt1/gnt1/rvalid1/rdata1: same widths and meanings as the thread 0 signals, for thread 1.
- mem_en  out  1  memory command valid.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after a read command.
- all_halted  out  1  halt0 & halt1 & no reads outstanding.

Behaviour:
- Effective request: ereqN = reqN & ~haltN.
- Grant logic (combinational, same cycle):
  - Only one ereq high: grant that thread.
  - Both high: grant the thread selected by register prio.
  - Neither high: no grant; gnt0=gnt1=mem_en=0.
- Memory command outputs are combinational from the winner: mem_en=1, mem_we=weN, mem_addr=addrN, mem_wdata=wdataN.
  - Idle values: mem_we=0, mem_addr=0, mem_wdata=0.
- prio register:
  - Reset value 0.
  - At each posedge with a grant, prio <= index of the thread NOT granted.
  - No grant: prio holds.
  - Guarantee: a continuously requesting thread waits at most 1 cycle.
- Requester rule: reqN, weN, addrN, wdataN are held stable until the cycle gntN=1. The arbiter does not queue requests; a deasserted request is simply not served.
- Read tag pipeline:
  - Shift register of MEM_LAT entries, each {valid, id}.
  - Stage 0 is loaded at posedge with {grant & ~mem_we, winner id}.
  - The tag exits after MEM_LAT cycles. In that cycle rvalid[id]=1 and rdata[id]=mem_rdata; the other thread sees rvalid=0 and rdata=0.
  - Writes create no tag and produce no rvalid.
- Back-to-back reads from alternating or same threads are fully pipelined: one grant per cycle, responses returned in issue order.
- Outstanding count = number of valid tags (0..MEM_LAT).
  - all_halted = halt0 & halt1 & (count==0).
  - Combinational; asserts the same cycle the last rvalid is returned only if halts are already high and no other tags remain.
- A halt asserted while a read is outstanding still delivers that read's rvalid.
- Reset, asynchronous, any time:
  - prio=0 and all tags cleared immediately.
  - rvalid0=rvalid1=0, rdata0=rdata1=0.
  - Data for reads issued before reset is discarded.
  - gnt and mem_* follow the combinational rules and are 0 when reset drives all requests low.
- The arbiter never issues more than one memory command per cycle and never grants both threads in the same cycle.

Test Plan:
- Reset, then idle: gnt0=gnt1=mem_en=rvalid*=0 and all_halted=0 (halts low); set halt0=halt1=1 -> all_halted=1.
- req0 only, load addr 0x0010, memory word 0x0010=0xBEEF, MEM_LAT=1: gnt0=1 and mem_en=1, mem_we=0, mem_addr=0x0010 in cycle N; rvalid0=1 and rdata0=0xBEEF in cycle N+1; rvalid1=0.
- Both threads request loads continuously from reset (addr0=0x0001, addr1=0x0002): grants alternate 0,1,0,1; rvalid pattern alternates one cycle later with correct data per thread.
- Thread 1 store (addr 0x0020, data 0x1234) concurrent with thread 0 load while prio=1: gnt1 first with mem_we=1, then gnt0 next cycle; no rvalid for the store; the thread 0 read returns after MEM_LAT.
- MEM_LAT=3, thread 0 issues a read, then halt0=halt1=1 next cycle: all_halted stays 0 until rvalid0 fires in cycle N+3, then goes to 1.
- Reset pulsed one cycle after a read grant (MEM_LAT=2): no rvalid ever appears for that read; prio=0 after reset, so simultaneous requests grant thread 0 first.
